// File: rtl/ddr2_traffic_checker_if.sv
// MIG DDR2 user-side bus: address/command FIFO, write data FIFO and read data return.
// The traffic checker drives it as master; the memory controller (or a model) is the slave.
interface ddr2_traffic_checker_if #(
  parameter int APPDATA_WIDTH = 32
);
  logic                       app_af_afull;
  logic                       app_wdf_afull;
  logic                       app_af_wren;
  logic [30:0]                app_af_addr;
  logic [2:0]                 app_af_cmd;
  logic                       app_wdf_wren;
  logic [APPDATA_WIDTH-1:0]   app_wdf_data;
  logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data;
  logic                       rd_data_valid;
  logic [APPDATA_WIDTH-1:0]   rd_data_fifo_out;

  modport master (
    input  app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    output app_af_wren, app_af_addr, app_af_cmd, app_wdf_wren, app_wdf_data, app_wdf_mask_data
  );

  modport slave (
    output app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    input  app_af_wren, app_af_addr, app_af_cmd, app_wdf_wren, app_wdf_data, app_wdf_mask_data
  );
endinterface

// File: rtl/ddr2_traffic_checker.sv
// DDR2 RAM tester on the MIG user side: writes num_bursts bursts in a chosen pattern,
// reads them back and compares each word against an independently regenerated pattern.
module ddr2_traffic_checker #(
  parameter int APPDATA_WIDTH = 32,
  parameter int BURST_LEN     = 4,
  parameter int NBURST_WIDTH  = 16,
  parameter int ERRCNT_WIDTH  = 16
) (
  input  logic                     clk0,
  input  logic                     rst0,
  input  logic                     phy_init_done,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [30:0]              addr_base,
  input  logic [NBURST_WIDTH-1:0]  num_bursts,
  ddr2_traffic_checker_if.master   mig,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ERRCNT_WIDTH-1:0]  error_count,
  output logic [30:0]              first_err_addr,
  output logic [APPDATA_WIDTH-1:0] first_err_data
);
  localparam int W     = APPDATA_WIDTH;
  localparam int WPB   = BURST_LEN / 2;
  localparam int LANES = W / 32;
  localparam logic [31:0] POLY      = 32'h8020_0003;
  localparam logic [31:0] SEED      = 32'hACE1_0001;
  localparam logic [30:0] ADDR_STEP = 31'(BURST_LEN);
  localparam logic [7:0]  WPB_M1    = 8'(WPB - 1);
  localparam logic [W-1:0] WALK0    = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    lfsr_step = (l >> 1) ^ (l[0] ? POLY : 32'h0);
  endfunction

  // w is the run-wide word index; walk is a one-hot that rotates once per word.
  function automatic logic [W-1:0] pattern(input logic [1:0] m, input logic [31:0] w,
                                           input logic [31:0] l, input logic [W-1:0] walk);
    case (m)
      2'd0:    pattern = {LANES{w}};
      2'd1:    pattern = {LANES{l}};
      2'd2:    pattern = walk;
      default: pattern = w[0] ? '0 : '1;
    endcase
  endfunction

  state_t                  state;
  logic [1:0]              mode_q;
  logic [30:0]             base_q;
  logic [NBURST_WIDTH-1:0] nb_m1;
  // generator side (shared by write and read-command phases)
  logic [30:0]             cur_addr;
  logic [NBURST_WIDTH-1:0] bcnt;
  logic [7:0]              wib;
  logic [31:0]             g_w, g_lfsr;
  logic [W-1:0]            g_walk;
  // checker side, advances only on accepted read words
  logic [30:0]             c_addr;
  logic [NBURST_WIDTH-1:0] c_bcnt;
  logic [7:0]              c_wib;
  logic [31:0]             c_w, c_lfsr;
  logic [W-1:0]            c_walk;
  logic                    rd_all;

  logic         accept, wr_go, rd_take, rd_last;
  logic [W-1:0] c_exp;

  assign accept  = start && phy_init_done && (state == IDLE || state == DONE);
  assign wr_go   = !mig.app_wdf_afull && !mig.app_af_afull;
  assign rd_take = mig.rd_data_valid && (state == READ || state == WAIT_RD) && !rd_all;
  assign rd_last = (c_bcnt == nb_m1) && (c_wib == WPB_M1);
  assign c_exp   = pattern(mode_q, c_w, c_lfsr, c_walk);
  assign mig.app_wdf_mask_data = '0;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state <= IDLE;
      mode_q <= '0; base_q <= '0; nb_m1 <= '0;
      cur_addr <= '0; bcnt <= '0; wib <= '0;
      g_w <= '0; g_lfsr <= SEED; g_walk <= WALK0;
      c_addr <= '0; c_bcnt <= '0; c_wib <= '0;
      c_w <= '0; c_lfsr <= SEED; c_walk <= WALK0;
      rd_all <= 1'b0;
      mig.app_af_wren <= 1'b0; mig.app_af_addr <= '0; mig.app_af_cmd <= '0;
      mig.app_wdf_wren <= 1'b0; mig.app_wdf_data <= '0;
      busy <= 1'b0; done <= 1'b0; error <= 1'b0; error_count <= '0;
      first_err_addr <= '0; first_err_data <= '0;
    end else begin
      mig.app_af_wren  <= 1'b0;
      mig.app_wdf_wren <= 1'b0;
      case (state)
        IDLE, DONE: if (accept) begin
          mode_q <= mode; base_q <= addr_base; nb_m1 <= num_bursts - 1'b1;
          cur_addr <= addr_base; bcnt <= '0; wib <= '0;
          g_w <= '0; g_lfsr <= SEED; g_walk <= WALK0;
          c_addr <= addr_base; c_bcnt <= '0; c_wib <= '0;
          c_w <= '0; c_lfsr <= SEED; c_walk <= WALK0;
          rd_all <= 1'b0;
          error <= 1'b0; error_count <= '0; first_err_addr <= '0; first_err_data <= '0;
          if (num_bursts == '0) begin
            state <= DONE; done <= 1'b1; busy <= 1'b0;
          end else begin
            state <= WRITE; done <= 1'b0; busy <= 1'b1;
          end
        end
        WRITE: if (wr_go) begin
          mig.app_wdf_wren <= 1'b1;
          mig.app_wdf_data <= pattern(mode_q, g_w, g_lfsr, g_walk);
          g_w <= g_w + 32'd1; g_lfsr <= lfsr_step(g_lfsr);
          g_walk <= {g_walk[W-2:0], g_walk[W-1]};
          if (wib == WPB_M1) begin
            // command rides with the last data word of its burst
            wib <= '0;
            mig.app_af_wren <= 1'b1; mig.app_af_cmd <= 3'b000; mig.app_af_addr <= cur_addr;
            if (bcnt == nb_m1) begin
              state <= READ; bcnt <= '0; cur_addr <= base_q;
            end else begin
              bcnt <= bcnt + 1'b1; cur_addr <= cur_addr + ADDR_STEP;
            end
          end else begin
            wib <= wib + 8'd1;
          end
        end
        READ: if (!mig.app_af_afull) begin
          mig.app_af_wren <= 1'b1; mig.app_af_cmd <= 3'b001; mig.app_af_addr <= cur_addr;
          cur_addr <= cur_addr + ADDR_STEP;
          if (bcnt == nb_m1) state <= WAIT_RD;
          else bcnt <= bcnt + 1'b1;
        end
        WAIT_RD: if (rd_all || (rd_take && rd_last)) begin
          state <= DONE; busy <= 1'b0; done <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (rd_take) begin
        if (mig.rd_data_fifo_out != c_exp) begin
          error <= 1'b1;
          if (error_count != '1) error_count <= error_count + 1'b1;
          if (!error) begin
            first_err_addr <= c_addr; first_err_data <= mig.rd_data_fifo_out;
          end
        end
        c_w <= c_w + 32'd1; c_lfsr <= lfsr_step(c_lfsr);
        c_walk <= {c_walk[W-2:0], c_walk[W-1]};
        if (c_wib == WPB_M1) begin
          c_wib <= '0; c_bcnt <= c_bcnt + 1'b1; c_addr <= c_addr + ADDR_STEP;
        end else begin
          c_wib <= c_wib + 8'd1;
        end
        if (rd_last) rd_all <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ddr2_traffic_checker.sv
// Bench for ddr2_traffic_checker: memory model on the MIG side, expected-traffic queues
// filled at run start and drained by a negedge monitor, plus end-of-run status checks.
module tb_ddr2_traffic_checker;
  localparam int W = 32, WPB = 2;

  logic clk0 = 1'b0, rst0 = 1'b1;
  always #5 clk0 = ~clk0;

  logic        phy_init_done, start;
  logic [1:0]  mode;
  logic [30:0] addr_base;
  logic [15:0] num_bursts;
  logic        busy, done, error;
  logic [15:0] error_count;
  logic [30:0] first_err_addr;
  logic [31:0] first_err_data;

  ddr2_traffic_checker_if #(.APPDATA_WIDTH(W)) mig();

  ddr2_traffic_checker dut (
    .clk0(clk0), .rst0(rst0), .phy_init_done(phy_init_done), .start(start),
    .mode(mode), .addr_base(addr_base), .num_bursts(num_bursts), .mig(mig),
    .busy(busy), .done(done), .error(error), .error_count(error_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  int n_chk = 0, n_err = 0;
  logic [31:0] exp_wd[$];
  logic [33:0] exp_cmd[$];
  logic [31:0] wpend[$];
  logic [31:0] rdq[$];
  bit          rdbad[$];
  logic [31:0] mem [longint];
  int rd_idx = 0, corrupt_idx = -1, corrupt_bit = 0;
  int wr_pushes = 0, af_pushes = 0, rd_words = 0, cyc = 0;
  bit tog_en = 1'b0, err_pend = 1'b0;
  logic wdf_afull_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pat(input logic [1:0] m, input int w);
    logic [31:0] l;
    l = 32'hACE1_0001;
    case (m)
      2'd0: model_pat = 32'(w);
      2'd1: begin
        for (int i = 0; i < w; i++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        model_pat = l;
      end
      2'd2: model_pat = 32'h1 << (w % 32);
      default: model_pat = (w % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
    endcase
  endfunction

  always @(posedge clk0) wdf_afull_q <= mig.app_wdf_afull;

  // Monitor + memory model + read responder + afull toggler
  always @(negedge clk0) begin
    if (!rst0) begin
      if (err_pend) begin chk("error_1cyc", error, 1); err_pend = 1'b0; end
      if (mig.app_wdf_wren) begin
        wr_pushes++;
        wpend.push_back(mig.app_wdf_data);
        chk("wdf_afull_hold", wdf_afull_q, 0);
        chk("wdf_mask", mig.app_wdf_mask_data, 0);
        if (exp_wd.size() == 0) chk("wdata_unexpected", exp_wd.size(), 1);
        else chk("wdata", mig.app_wdf_data, exp_wd.pop_front());
      end
      if (mig.app_af_wren) begin
        af_pushes++;
        if (exp_cmd.size() == 0) chk("cmd_unexpected", exp_cmd.size(), 1);
        else chk("cmd_addr", {mig.app_af_cmd, mig.app_af_addr}, exp_cmd.pop_front());
        if (mig.app_af_cmd == 3'b000) begin
          chk("wdata_before_cmd", wpend.size(), WPB);
          for (int i = 0; i < WPB && wpend.size() != 0; i++)
            mem[longint'(mig.app_af_addr) * WPB + i] = wpend.pop_front();
        end else begin
          for (int i = 0; i < WPB; i++) begin
            logic [31:0] d;
            longint k;
            bit bad;
            k = longint'(mig.app_af_addr) * WPB + i;
            d = mem.exists(k) ? mem[k] : 32'h0;
            bad = (rd_idx == corrupt_idx);
            if (bad) d = d ^ (32'h1 << corrupt_bit);
            rdq.push_back(d); rdbad.push_back(bad);
            rd_idx++;
          end
        end
      end
    end
    cyc++;
    if (rdq.size() != 0 && (!tog_en || cyc % 4 != 0)) begin
      mig.rd_data_valid = 1'b1;
      mig.rd_data_fifo_out = rdq.pop_front();
      rd_words++;
      if (rdbad.pop_front()) begin chk("error_before", error, 0); err_pend = 1'b1; end
    end else begin
      mig.rd_data_valid = 1'b0;
      mig.rd_data_fifo_out = '0;
    end
    mig.app_wdf_afull = tog_en && ((cyc / 3) % 2 == 1);
  end

  task automatic expect_run(input logic [1:0] m, input logic [30:0] base, input int nb);
    for (int w = 0; w < nb * WPB; w++) exp_wd.push_back(model_pat(m, w));
    for (int b = 0; b < nb; b++) exp_cmd.push_back({3'b000, 31'(base + 31'(b * 4))});
    for (int b = 0; b < nb; b++) exp_cmd.push_back({3'b001, 31'(base + 31'(b * 4))});
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [30:0] base, input int nb);
    wr_pushes = 0; af_pushes = 0; rd_words = 0; rd_idx = 0;
    mode = m; addr_base = base; num_bursts = 16'(nb);
    start = 1'b1;
    @(negedge clk0); #1;
    start = 1'b0;
  endtask

  task automatic run(input string nm, input logic [1:0] m, input logic [30:0] base, input int nb);
    expect_run(m, base, nb);
    pulse_start(m, base, nb);
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk0);
    #1;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_wdata_left"}, exp_wd.size(), 0);
    chk({nm, "_cmd_left"}, exp_cmd.size(), 0);
    chk({nm, "_rd_words"}, rd_words, nb * WPB);
  endtask

  initial begin
    phy_init_done = 1'b1; start = 1'b0; mode = 2'd0; addr_base = '0; num_bursts = '0;
    mig.app_af_afull = 1'b0;
    repeat (3) @(negedge clk0);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_error", error, 0);
    chk("rst_errcnt", error_count, 0); chk("rst_af_wren", mig.app_af_wren, 0);
    chk("rst_wdf_wren", mig.app_wdf_wren, 0); chk("rst_first_addr", first_err_addr, 0);
    rst0 = 1'b0;
    @(negedge clk0); #1;

    // start ignored until calibration completes
    phy_init_done = 1'b0;
    pulse_start(2'd0, '0, 4);
    chk("nophy_busy", busy, 0);
    phy_init_done = 1'b1;

    // 1: address pattern, 4 bursts from 0
    run("t1", 2'd0, 31'h0, 4);
    chk("t1_wr_pushes", wr_pushes, 8); chk("t1_af_pushes", af_pushes, 8);
    chk("t1_error", error, 0); chk("t1_errcnt", error_count, 0);

    // 2: LFSR, 16 bursts, write FIFO almost-full toggling
    tog_en = 1'b1;
    run("t2", 2'd1, 31'h100, 16);
    tog_en = 1'b0;
    chk("t2_error", error, 0); chk("t2_errcnt", error_count, 0);

    // 3: corrupt bit 5 of read word 3
    corrupt_idx = 3; corrupt_bit = 5;
    run("t3", 2'd0, 31'h0, 4);
    corrupt_idx = -1;
    chk("t3_error", error, 1); chk("t3_errcnt", error_count, 1);
    chk("t3_first_addr", first_err_addr, 31'h4); chk("t3_first_data", first_err_data, 32'h23);

    // 4: address wrap at 2^31
    run("t4", 2'd0, 31'h7FFF_FFFC, 2);
    chk("t4_error_cleared", error, 0); chk("t4_errcnt", error_count, 0);

    // 5: reset mid-WRITE
    expect_run(2'd0, 31'h0, 4);
    pulse_start(2'd0, 31'h0, 4);
    @(negedge clk0); #1;
    rst0 = 1'b1; #1;
    chk("t5_busy", busy, 0); chk("t5_done", done, 0);
    chk("t5_af_wren", mig.app_af_wren, 0); chk("t5_wdf_wren", mig.app_wdf_wren, 0);
    chk("t5_wdf_data", mig.app_wdf_data, 0); chk("t5_af_addr", mig.app_af_addr, 0);
    @(negedge clk0); #1;
    rst0 = 1'b0;
    exp_wd.delete(); exp_cmd.delete(); wpend.delete(); rdq.delete(); rdbad.delete();
    run("t5b", 2'd3, 31'h40, 4);
    chk("t5b_error", error, 0);

    // walking one across more than APPDATA_WIDTH words
    run("walk", 2'd2, 31'h200, 20);
    chk("walk_error", error, 0);

    // 6: zero bursts
    pulse_start(2'd0, 31'h0, 0);
    chk("t6_done", done, 1); chk("t6_busy", busy, 0);
    repeat (3) @(negedge clk0);
    #1;
    chk("t6_wr_pushes", wr_pushes, 0); chk("t6_af_pushes", af_pushes, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
